// File: rtl/ysyx_23060203_clint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060203_clint_pkg
// Description : Shared types, constants and beat-decode helpers for the CLINT
//               read responder (state encoding, AXI response codes, register
//               offsets).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060203_clint_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [31:0] MTIME_LO = 32'h0000_0000;
   localparam logic [31:0] MTIME_HI = 32'h0000_0004;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } beat_t;

   // Bursts wider than 32 bits or of WRAP type are rejected wholesale.
   function automatic logic is_bad_req(input logic [2:0] size, input logic [1:0] burst);
      return (size > 3'd2) || (burst == BURST_WRAP);
   endfunction

   // Response/data for one beat, given the word-aligned offset and snapshot.
   function automatic beat_t decode_beat(input logic bad, input logic [31:0] off,
                                         input logic [63:0] snap);
      beat_t b;
      b.resp = OKAY;
      b.data = '0;
      if (bad) begin
         b.resp = SLVERR;
      end else if (off == MTIME_LO) begin
         b.data = snap[31:0];
      end else if (off == MTIME_HI) begin
         b.data = snap[63:32];
      end else begin
         b.resp = DECERR;
      end
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_clint_mtime.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060203_clint_mtime
// Description : Free-running 64-bit mtime counter with a 0..DIV-1 prescaler.
// Ports       : clock - system clock
//               reset - synchronous, active-high
//               mtime - live 64-bit counter value
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060203_clint_mtime #(
   parameter int DIV = 1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [63:0] mtime
);

   logic [63:0] count;
   logic        tick;

   generate
      if (DIV <= 1) begin : g_no_prescale
         assign tick = 1'b1;
      end else begin : g_prescale
         localparam int PW = $clog2(DIV);
         localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
         logic [PW-1:0] pre;

         always_ff @(posedge clock) begin
            if (reset) begin
               pre <= '0;
            end else if (pre == PRE_MAX) begin
               pre <= '0;
            end else begin
               pre <= pre + PW'(1);
            end
         end

         // Tick on the last prescaler value so the first increment lands
         // exactly DIV cycles after reset.
         assign tick = (pre == PRE_MAX);
      end
   endgenerate

   // Natural 64-bit overflow gives the all-ones -> 0 wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 64'd1;
      end
   end

   assign mtime = count;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_clint.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060203_clint
// Description : AXI4 read-slave for the CLINT. Keeps a free-running mtime
//               and serves single/burst reads from a per-transaction
//               snapshot so multi-beat reads see a coherent 64-bit value.
// Ports       : clock, reset           - clock, sync active-high reset
//               arvalid/arready/araddr/arid/arlen/arsize/arburst - AR channel
//               rvalid/rready/rdata/rresp/rlast/rid             - R channel
//               mtime                  - live counter for timer compare logic
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060203_clint
   import ysyx_23060203_clint_pkg::*;
#(
   parameter int DIV      = 1,
   parameter int OFF_BITS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid,
   output logic [63:0] mtime
);

   state_t              state;
   state_t              state_next;

   logic [63:0]         snap;
   logic [OFF_BITS-1:0] off_q;
   logic [OFF_BITS-1:0] off_next;
   logic [OFF_BITS-1:0] ar_off;
   logic [7:0]          len_q;
   logic [7:0]          beat_q;
   logic [1:0]          burst_q;
   logic [2:0]          size_q;
   logic                ar_hs;
   logic                r_hs;
   beat_t               ar_beat;
   beat_t               nx_beat;
   logic                unused_addr;

   ysyx_23060203_clint_mtime #(
      .DIV (DIV)
   ) u_mtime (
      .clock (clock),
      .reset (reset),
      .mtime (mtime)
   );

   assign ar_hs = arvalid & arready;
   assign r_hs  = rvalid & rready;

   // Upper address bits were matched by the crossbar; byte lane bits are
   // ignored because every register is a full 32-bit word.
   assign unused_addr = ^{araddr[31:OFF_BITS], araddr[1:0]};
   assign ar_off      = {araddr[OFF_BITS-1:2], 2'b00};
   assign off_next    = (burst_q == BURST_INCR) ? off_q + OFF_BITS'(4) : off_q;

   // First beat decodes straight from the live counter: that is exactly the
   // value being captured into the snapshot on this edge.
   assign ar_beat = decode_beat(is_bad_req(arsize, arburst), 32'(ar_off), mtime);
   assign nx_beat = decode_beat(is_bad_req(size_q, burst_q), 32'(off_next), snap);

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clock) begin : p_state
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin : p_next
      state_next = state;
      case (state)
         IDLE:    if (ar_hs) state_next = BURST;
         BURST:   if (r_hs && rlast) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // arready is masked by reset so nothing is accepted while reset is held,
   // whatever state the register happens to hold at that moment.
   always_comb begin : p_out
      arready = 1'b0;
      rvalid  = 1'b0;
      case (state)
         IDLE:    arready = ~reset;
         BURST:   rvalid  = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------- datapath -------
   // R outputs are registered one beat ahead: loaded at AR accept, then
   // reloaded on every non-final R handshake, held otherwise.
   always_ff @(posedge clock) begin : p_data
      if (reset) begin
         snap    <= '0;
         off_q   <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         burst_q <= '0;
         size_q  <= '0;
         rdata   <= '0;
         rresp   <= '0;
         rlast   <= 1'b0;
         rid     <= '0;
      end else if (ar_hs) begin
         snap    <= mtime;
         off_q   <= ar_off;
         len_q   <= arlen;
         beat_q  <= '0;
         burst_q <= arburst;
         size_q  <= arsize;
         rid     <= arid;
         rdata   <= ar_beat.data;
         rresp   <= ar_beat.resp;
         rlast   <= (arlen == 8'd0);
      end else if (r_hs && !rlast) begin
         beat_q  <= beat_q + 8'd1;
         off_q   <= off_next;
         rdata   <= nx_beat.data;
         rresp   <= nx_beat.resp;
         rlast   <= ((beat_q + 8'd1) == len_q);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_clint.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060203_clint
// Description : Self-checking bench for the CLINT read responder (DIV=1 main
//               instance plus a DIV=4 instance for prescaler checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060203_clint;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        arvalid = 1'b0;
   logic [31:0] araddr = '0;
   logic [3:0]  arid = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        rready = 1'b0;
   logic        arready, rvalid, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rid;
   logic [63:0] mtime;

   logic        d4_arvalid = 1'b0;
   logic [31:0] d4_araddr = '0;
   logic [3:0]  d4_arid = '0;
   logic [7:0]  d4_arlen = '0;
   logic [2:0]  d4_arsize = '0;
   logic [1:0]  d4_arburst = '0;
   logic        d4_rready = 1'b0;
   logic        d4_arready, d4_rvalid, d4_rlast;
   logic [31:0] d4_rdata;
   logic [1:0]  d4_rresp;
   logic [3:0]  d4_rid;
   logic [63:0] mtime4;

   int checks = 0;
   int fails  = 0;

   // Reference time: mtime (DIV=1) equals the number of edges since reset,
   // offset when the bench forces the counter to a chosen value.
   longint unsigned cyc = 0;
   logic [63:0]     ref_base = '0;
   longint unsigned ref_cyc0 = 0;

   logic [31:0] q_data[$];
   logic [1:0]  q_resp[$];
   logic        q_last[$];
   logic [3:0]  q_id[$];

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   ysyx_23060203_clint #(.DIV(1), .OFF_BITS(16)) dut (
      .clock(clock), .reset(reset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rid(rid), .mtime(mtime)
   );

   ysyx_23060203_clint #(.DIV(4), .OFF_BITS(16)) dut4 (
      .clock(clock), .reset(reset),
      .arvalid(d4_arvalid), .arready(d4_arready), .araddr(d4_araddr), .arid(d4_arid),
      .arlen(d4_arlen), .arsize(d4_arsize), .arburst(d4_arburst),
      .rvalid(d4_rvalid), .rready(d4_rready), .rdata(d4_rdata), .rresp(d4_rresp),
      .rlast(d4_rlast), .rid(d4_rid), .mtime(mtime4)
   );

   function automatic logic [63:0] exp_mtime();
      return ref_base + 64'(cyc - ref_cyc0);
   endfunction

   // Expected beat i of a burst, straight from the register map rules.
   function automatic void model_beat(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst, input logic [7:0] len,
                                      input logic [63:0] snap, input int i,
                                      output logic [31:0] data, output logic [1:0] resp,
                                      output logic last);
      int unsigned off;
      off  = (int'(addr & 32'h0000_FFFC) + ((burst == 2'b01) ? 4 * i : 0)) % 65536;
      last = (i == int'(len));
      if (size > 3'd2 || burst == 2'b10) begin
         data = 32'h0; resp = 2'b10;
      end else if (off == 0) begin
         data = snap[31:0]; resp = 2'b00;
      end else if (off == 4) begin
         data = snap[63:32]; resp = 2'b00;
      end else begin
         data = 32'h0; resp = 2'b11;
      end
   endfunction

   // Issues one AR at the current negedge and collects the R beats. Protocol
   // violations (late first beat, gaps, unstable data under stall, arready
   // during the burst, missing termination) accumulate in viol.
   task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_first, input int stall_pct,
                            output logic [63:0] snap, output int nbeats, output int viol);
      int guard, stalled;
      logic prev_stall, done;
      logic [31:0] pd; logic [1:0] pr; logic pl; logic [3:0] pi;
      q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
      viol = 0; nbeats = 0; snap = '0; stalled = 0; prev_stall = 1'b0; done = 1'b0;
      pd = '0; pr = '0; pl = 1'b0; pi = '0;
      araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
      arvalid = 1'b1;
      guard = 0;
      while (arready !== 1'b1 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (arready !== 1'b1) begin
         arvalid = 1'b0;
         viol++;
         return;
      end
      snap = exp_mtime();
      @(negedge clock);
      arvalid = 1'b0;
      guard = 0;
      while (!done && guard < 4000) begin
         if (rvalid !== 1'b1) begin
            viol++;
            done = 1'b1;
         end else begin
            if (arready !== 1'b0) viol++;
            if (prev_stall && ({rdata, rresp, rlast, rid} !== {pd, pr, pl, pi})) viol++;
            if (nbeats == 0 && stalled < stall_first) begin
               rready = 1'b0;
               stalled++;
            end else begin
               rready = ($urandom_range(0, 99) >= stall_pct);
            end
            pd = rdata; pr = rresp; pl = rlast; pi = rid;
            prev_stall = !rready;
            if (rready) begin
               q_data.push_back(rdata); q_resp.push_back(rresp);
               q_last.push_back(rlast); q_id.push_back(rid);
               nbeats++;
            end
            @(negedge clock);
            if (rready && pl) begin
               done = 1'b1;
               if (rvalid !== 1'b0 || arready !== 1'b1) viol++;
            end
            rready = 1'b0;
            guard++;
         end
      end
      if (!done) viol++;
      rready = 1'b0;
   endtask

   task automatic check_burst(input string name, input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input logic [63:0] snap, input int n, input int viol);
      logic [31:0] ed; logic [1:0] er; logic el;
      checks++;
      if (viol != 0) begin
         fails++;
         $display("FAIL %s protocol: got %0d violations, want 0", name, viol);
      end
      checks++;
      if (n != int'(len) + 1) begin
         fails++;
         $display("FAIL %s beats: got %0d, want %0d", name, n, int'(len) + 1);
      end
      for (int i = 0; i < n && i <= int'(len); i++) begin
         model_beat(addr, size, burst, len, snap, i, ed, er, el);
         checks++;
         if ({q_data[i], q_resp[i], q_last[i], q_id[i]} !== {ed, er, el, id}) begin
            fails++;
            $display("FAIL %s beat%0d: got data=%h resp=%b last=%b id=%h, want data=%h resp=%b last=%b id=%h",
                     name, i, q_data[i], q_resp[i], q_last[i], q_id[i], ed, er, el, id);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (arready !== 1'b0 || mtime !== 64'd0) begin
         fails++;
         $display("FAIL reset_hold: got arready=%b mtime=%h, want arready=0 mtime=0", arready, mtime);
      end
      reset = 1'b0; ref_base = '0; ref_cyc0 = 0;
      @(negedge clock);
      checks++;
      if ({arready, rvalid, rlast, rdata, rresp, rid} !== {1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 4'h0}) begin
         fails++;
         $display("FAIL reset_values: got arready=%b rvalid=%b rlast=%b rdata=%h rresp=%b rid=%h, want 1 0 0 0 0 0",
                  arready, rvalid, rlast, rdata, rresp, rid);
      end
      checks++;
      if (mtime !== exp_mtime()) begin
         fails++;
         $display("FAIL reset_mtime: got %h, want %h", mtime, exp_mtime());
      end
   endtask

   task automatic test_single();
      logic [63:0] snap; int n, viol;
      repeat (10) @(negedge clock);
      run_burst(32'h0200_0000, 4'd3, 8'd0, 3'd2, 2'b01, 0, 0, snap, n, viol);
      check_burst("single", 32'h0200_0000, 4'd3, 8'd0, 3'd2, 2'b01, snap, n, viol);
   endtask

   task automatic test_prescaler();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0; ref_base = '0; ref_cyc0 = 0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (mtime4 !== 64'(k / 4) || mtime !== 64'(k)) begin
            fails++;
            $display("FAIL prescaler k=%0d: got mtime4=%0d mtime=%0d, want %0d %0d", k, mtime4, mtime, k / 4, k);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_coherent();
      logic [63:0] snap; int n, viol;
      force dut.u_mtime.count = 64'h0000_0000_FFFF_FFFF;
      @(negedge clock);
      release dut.u_mtime.count;
      ref_base = 64'h0000_0000_FFFF_FFFF; ref_cyc0 = cyc;
      run_burst(32'h0200_0000, 4'd7, 8'd1, 3'd2, 2'b01, 3, 0, snap, n, viol);
      check_burst("coherent", 32'h0200_0000, 4'd7, 8'd1, 3'd2, 2'b01, snap, n, viol);
      checks++;
      if (q_data[0] !== 32'hFFFF_FFFF || q_data[1] !== 32'h0) begin
         fails++;
         $display("FAIL coherent_pair: got %h/%h, want ffffffff/00000000", q_data[0], q_data[1]);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] snap; int n, viol;
      repeat (2) @(negedge clock);
      run_burst(32'h0000_0000, 4'd5, 8'd1, 3'd2, 2'b01, 5, 0, snap, n, viol);
      check_burst("backpressure", 32'h0, 4'd5, 8'd1, 3'd2, 2'b01, snap, n, viol);
   endtask

   task automatic test_errors();
      logic [63:0] snap; int n, viol;
      run_burst(32'h0000_0008, 4'd1, 8'd0, 3'd2, 2'b01, 0, 0, snap, n, viol);
      check_burst("decerr", 32'h8, 4'd1, 8'd0, 3'd2, 2'b01, snap, n, viol);
      checks++;
      if (q_resp[0] !== 2'b11 || q_data[0] !== 32'h0) begin
         fails++;
         $display("FAIL decerr_const: got resp=%b data=%h, want 11 0", q_resp[0], q_data[0]);
      end
      run_burst(32'h0000_0000, 4'd2, 8'd0, 3'd3, 2'b01, 0, 0, snap, n, viol);
      check_burst("size3", 32'h0, 4'd2, 8'd0, 3'd3, 2'b01, snap, n, viol);
      checks++;
      if (q_resp[0] !== 2'b10 || q_data[0] !== 32'h0) begin
         fails++;
         $display("FAIL size3_const: got resp=%b data=%h, want 10 0", q_resp[0], q_data[0]);
      end
      run_burst(32'h0000_0000, 4'd4, 8'd3, 3'd2, 2'b10, 0, 20, snap, n, viol);
      check_burst("wrap", 32'h0, 4'd4, 8'd3, 3'd2, 2'b10, snap, n, viol);
      run_burst(32'h0000_0004, 4'd6, 8'd2, 3'd2, 2'b00, 0, 20, snap, n, viol);
      check_burst("fixed_hi", 32'h4, 4'd6, 8'd2, 3'd2, 2'b00, snap, n, viol);
   endtask

   task automatic test_random();
      logic [63:0] snap; int n, viol;
      for (int t = 0; t < 25; t++) begin
         logic [31:0] addr; logic [15:0] lo; logic [7:0] len;
         logic [2:0] size; logic [1:0] burst; logic [3:0] id;
         case ($urandom_range(0, 5))
            0:       lo = 16'h0000;
            1:       lo = 16'h0004;
            2:       lo = 16'h0008;
            3:       lo = 16'hFFF8;
            4:       lo = 16'hFFFC;
            default: lo = 16'($urandom);
         endcase
         addr  = {16'($urandom), lo[15:2], 2'($urandom)};
         len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 2));
         size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         burst = 2'($urandom_range(0, 2));
         id    = 4'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clock);
         run_burst(addr, id, len, size, burst, 0, 30, snap, n, viol);
         check_burst("random", addr, id, len, size, burst, snap, n, viol);
      end
   endtask

   task automatic test_long();
      logic [63:0] snap; int n, viol;
      run_burst(32'h0200_FFF8, 4'hA, 8'd255, 3'd2, 2'b01, 0, 10, snap, n, viol);
      check_burst("len256", 32'h0200_FFF8, 4'hA, 8'd255, 3'd2, 2'b01, snap, n, viol);
   endtask

   task automatic test_wrap64();
      force dut.u_mtime.count = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clock);
      release dut.u_mtime.count;
      ref_base = 64'hFFFF_FFFF_FFFF_FFFF; ref_cyc0 = cyc;
      checks++;
      if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         fails++;
         $display("FAIL wrap_allones: got %h, want ffffffffffffffff", mtime);
      end
      @(negedge clock);
      checks++;
      if (mtime !== 64'h0) begin
         fails++;
         $display("FAIL wrap_zero: got %h, want 0", mtime);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (mtime !== exp_mtime()) begin
         fails++;
         $display("FAIL wrap_continue: got %h, want %h", mtime, exp_mtime());
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [63:0] snap; int n, viol, hs, guard;
      araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'd9;
      arvalid = 1'b1;
      @(negedge clock);
      arvalid = 1'b0;
      rready = 1'b1;
      hs = 0; guard = 0;
      while (hs < 3 && guard < 20) begin
         if (rvalid === 1'b1) hs++;
         @(negedge clock);
         guard++;
      end
      checks++;
      if (hs != 3 || rvalid !== 1'b1 || rlast !== 1'b0) begin
         fails++;
         $display("FAIL midburst_pre: got hs=%0d rvalid=%b rlast=%b, want 3 1 0", hs, rvalid, rlast);
      end
      rready = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
         fails++;
         $display("FAIL midburst_reset: got rvalid=%b rlast=%b arready=%b, want 0 0 0", rvalid, rlast, arready);
      end
      reset = 1'b0; ref_base = '0; ref_cyc0 = 0;
      @(negedge clock);
      checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         fails++;
         $display("FAIL midburst_release: got arready=%b rvalid=%b, want 1 0", arready, rvalid);
      end
      run_burst(32'h0000_0004, 4'd2, 8'd0, 3'd2, 2'b01, 0, 0, snap, n, viol);
      check_burst("after_reset", 32'h4, 4'd2, 8'd0, 3'd2, 2'b01, snap, n, viol);
   endtask

   initial begin
      test_reset();
      test_single();
      test_prescaler();
      test_coherent();
      test_backpressure();
      test_errors();
      test_random();
      test_long();
      test_wrap64();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
